// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt/trap controller: FSM states, cause codes,
// CSR addresses, mstatus bit positions and the registered CSR-write/redirect payload.
package irq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MSTATUS = 3'd2,
    S_MCAUSE  = 3'd3,
    S_MRET    = 3'd4
  } state_e;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_INT    = 32'h8000_0000;
  localparam int unsigned IRQ_BASE     = 16;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam logic [31:0] INST_ECALL   = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] INST_MRET    = 32'h3020_0073;

  typedef struct packed {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] data;
    logic        int_assert;
    logic [31:0] int_addr;
  } csr_wr_t;

  function automatic logic [31:0] csr_waddr(input logic [11:0] addr);
    return {20'h0, addr};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the pending, enabled interrupt sources.
module irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [4:0]         id
);

  // Scan downward so the lowest set index is the last assignment to stick.
  always_comb begin
    valid = 1'b0;
    id    = 5'd0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = 5'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode trap controller: detects ECALL/EBREAK, external interrupts and MRET,
// sequences the mepc/mstatus/mcause CSR writes and redirects the execute stage.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned VECTORED_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               global_int_en_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               div_started_i,
  input  logic [31:0]        csr_mtvec,
  input  logic [31:0]        csr_mepc,
  input  logic [31:0]        csr_mstatus,
  output logic               hold_flag_o,
  output logic               we_o,
  output logic [31:0]        waddr_o,
  output logic [31:0]        data_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o,
  output logic [4:0]         irq_id_o
);

  state_e      state, state_next;
  logic        pend_valid;
  logic [4:0]  pend_id;
  logic        in_idle, is_ecall, is_ebreak, is_mret;
  logic        sync_trap, async_trap, mret_evt;
  logic [31:0] mepc_q, cause_q;
  logic        async_q;
  logic [31:0] trap_target;
  csr_wr_t     wr_d, wr_q;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .req   (irq_i & irq_en_i),
    .valid (pend_valid),
    .id    (pend_id)
  );

  // Event detection only while idle, in fixed priority order.
  assign in_idle    = (state == S_IDLE);
  assign is_ecall   = (inst_i == INST_ECALL);
  assign is_ebreak  = (inst_i == INST_EBREAK);
  assign is_mret    = (inst_i == INST_MRET);
  assign sync_trap  = in_idle && (is_ecall || is_ebreak) && !div_started_i;
  assign async_trap = in_idle && !sync_trap && pend_valid && global_int_en_i;
  assign mret_evt   = in_idle && !sync_trap && !async_trap && is_mret;

  assign hold_flag_o = !rst && (sync_trap || async_trap || mret_evt || !in_idle);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (sync_trap || async_trap) state_next = S_MEPC;
        else if (mret_evt)           state_next = S_MRET;
      end
      S_MEPC:    state_next = S_MSTATUS;
      S_MSTATUS: state_next = S_MCAUSE;
      S_MCAUSE:  state_next = S_IDLE;
      S_MRET:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Trap context captured in the detection cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mepc_q   <= 32'h0;
      cause_q  <= 32'h0;
      async_q  <= 1'b0;
      irq_id_o <= 5'd0;
    end else if (sync_trap) begin
      mepc_q  <= jump_flag_i ? (jump_addr_i - 32'd4) : inst_addr_i;
      cause_q <= is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
      async_q <= 1'b0;
    end else if (async_trap) begin
      mepc_q   <= jump_flag_i   ? jump_addr_i :
                  div_started_i ? (inst_addr_i - 32'd4) : inst_addr_i;
      cause_q  <= CAUSE_INT | (32'(IRQ_BASE) + 32'(pend_id));
      async_q  <= 1'b1;
      irq_id_o <= pend_id;
    end
  end

  always_comb begin
    trap_target = {csr_mtvec[31:2], 2'b00};
    if (VECTORED_EN != 0 && csr_mtvec[1:0] == 2'b01 && async_q)
      trap_target = trap_target + ((32'(IRQ_BASE) + 32'(irq_id_o)) << 2);
  end

  always_comb begin
    wr_d = '0;
    case (state)
      S_MEPC: begin
        wr_d.we    = 1'b1;
        wr_d.waddr = csr_waddr(CSR_MEPC);
        wr_d.data  = mepc_q;
      end
      S_MSTATUS: begin
        wr_d.we                 = 1'b1;
        wr_d.waddr              = csr_waddr(CSR_MSTATUS);
        wr_d.data               = csr_mstatus;
        wr_d.data[MSTATUS_MPIE] = csr_mstatus[MSTATUS_MIE];
        wr_d.data[MSTATUS_MIE]  = 1'b0;
      end
      S_MCAUSE: begin
        wr_d.we         = 1'b1;
        wr_d.waddr      = csr_waddr(CSR_MCAUSE);
        wr_d.data       = cause_q;
        wr_d.int_assert = 1'b1;
        wr_d.int_addr   = trap_target;
      end
      S_MRET: begin
        wr_d.we                 = 1'b1;
        wr_d.waddr              = csr_waddr(CSR_MSTATUS);
        wr_d.data               = csr_mstatus;
        wr_d.data[MSTATUS_MIE]  = csr_mstatus[MSTATUS_MPIE];
        wr_d.data[MSTATUS_MPIE] = 1'b1;
        wr_d.int_assert         = 1'b1;
        wr_d.int_addr           = csr_mepc;
      end
      default: wr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) wr_q <= '0;
    else     wr_q <= wr_d;
  end

  assign we_o         = wr_q.we;
  assign waddr_o      = wr_q.waddr;
  assign data_o       = wr_q.data;
  assign int_assert_o = wr_q.int_assert;
  assign int_addr_o   = wr_q.int_addr;

endmodule
